// File: rtl/scr1_vexu_pkg.sv
// Shared definitions for the vector execute controller: opcode and FSM state encodings.
package scr1_vexu_pkg;

    typedef enum logic [3:0] {
        VEXU_OP_ADD = 4'd0,
        VEXU_OP_SUB = 4'd1,
        VEXU_OP_AND = 4'd2,
        VEXU_OP_OR  = 4'd3,
        VEXU_OP_XOR = 4'd4,
        VEXU_OP_SLL = 4'd5,
        VEXU_OP_SRL = 4'd6,
        VEXU_OP_MUL = 4'd7
    } type_scr1_vexu_op_e;

    typedef enum logic [1:0] {
        VEXU_FSM_IDLE = 2'd0,
        VEXU_FSM_EXEC = 2'd1,
        VEXU_FSM_WB   = 2'd2
    } type_scr1_vexu_fsm_e;

    // Opcodes 8..15 are reserved; the top bit alone identifies them.
    function automatic logic vexu_op_legal(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/vexu_lane_alu.sv
// Single-lane element ALU; purely combinational, all results modulo 2^EW.
module vexu_lane_alu
    import scr1_vexu_pkg::*;
#(
    parameter int EW = 32
) (
    input  logic [3:0]    op,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    output logic [EW-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            VEXU_OP_ADD: result = a + b;
            VEXU_OP_SUB: result = a - b;
            VEXU_OP_AND: result = a & b;
            VEXU_OP_OR:  result = a | b;
            VEXU_OP_XOR: result = a ^ b;
            VEXU_OP_SLL: result = a << b[4:0];
            VEXU_OP_SRL: result = a >> b[4:0];
            // Assignment context is EW bits wide, so only the low half of the product is kept.
            VEXU_OP_MUL: result = a * b;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/vexu_ctrl.sv
// Vector execute controller: accepts one instruction, reads the VRF, computes per-lane
// results with vl/mask gating and writes them back in a single WB cycle.
//
// Handshake: an instruction is consumed on a rising clk edge where dec2vexu_valid and
// dec2vexu_ready are both high; ready is high only in IDLE and valid may be held freely.
module vexu_ctrl
    import scr1_vexu_pkg::*;
#(
    parameter int LANE    = 8,
    parameter int EW      = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec2vexu_valid,
    output logic                 dec2vexu_ready,
    input  logic [3:0]           dec2vexu_op,
    input  logic [4:0]           dec2vexu_rd,
    input  logic [4:0]           dec2vexu_rs1,
    input  logic [4:0]           dec2vexu_rs2,
    input  logic                 dec2vexu_vm,
    input  logic [3:0]           dec2vexu_vl,
    output logic [4:0]           vexu2vrf_rs1_addr,
    output logic [4:0]           vexu2vrf_rs2_addr,
    input  logic [LANE*EW-1:0]   vrf2vexu_rs1_data,
    input  logic [LANE*EW-1:0]   vrf2vexu_rs2_data,
    input  logic [LANE*EW-1:0]   vrf2vexu_mask_data,
    output logic [4:0]           vexu2vrf_rd_addr,
    output logic [LANE-1:0]      vexu2vrf_rd_wreq,
    output logic [LANE*EW-1:0]   vexu2vrf_rd_wdata,
    output logic                 vexu2dec_done,
    output logic                 vexu2dec_illegal,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] ST_IDLE = VEXU_FSM_IDLE;
    localparam logic [1:0] ST_EXEC = VEXU_FSM_EXEC;
    localparam logic [1:0] ST_WB   = VEXU_FSM_WB;
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [1:0]         state;
    logic [3:0]         op_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic               vm_q;
    logic [3:0]         vl_q;
    logic [CNT_W-1:0]   cnt;
    logic [LANE*EW-1:0] res_q;
    logic [LANE-1:0]    wen_q;
    logic               illegal_q;

    logic               accept;
    logic [3:0]         vl_clamped;
    logic [LANE*EW-1:0] lane_res;
    logic [LANE-1:0]    lane_wen;

    assign accept     = dec2vexu_valid & dec2vexu_ready;
    assign vl_clamped = (dec2vexu_vl > 4'(LANE)) ? 4'(LANE) : dec2vexu_vl;

    for (genvar i = 0; i < LANE; i++) begin : g_lane
        vexu_lane_alu #(.EW(EW)) u_alu (
            .op     (op_q),
            .a      (vrf2vexu_rs1_data[i*EW +: EW]),
            .b      (vrf2vexu_rs2_data[i*EW +: EW]),
            .result (lane_res[i*EW +: EW])
        );
        // Mask is bit 0 of each v1 element.
        assign lane_wen[i] = (vl_q > 4'(i)) & (vm_q | vrf2vexu_mask_data[i*EW]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            vm_q      <= 1'b0;
            vl_q      <= '0;
            cnt       <= '0;
            res_q     <= '0;
            wen_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (vexu_op_legal(dec2vexu_op)) begin
                            op_q  <= dec2vexu_op;
                            rd_q  <= dec2vexu_rd;
                            rs1_q <= dec2vexu_rs1;
                            rs2_q <= dec2vexu_rs2;
                            vm_q  <= dec2vexu_vm;
                            vl_q  <= vl_clamped;
                            cnt   <= (dec2vexu_op == VEXU_OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
                            state <= ST_EXEC;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    // Operands are re-read every EXEC cycle; the last capture is what WB writes.
                    res_q <= lane_res;
                    wen_q <= lane_wen;
                    if (cnt == '0) state <= ST_WB;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_WB:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dec2vexu_ready    = (state == ST_IDLE);
    assign vexu2vrf_rs1_addr = rs1_q;
    assign vexu2vrf_rs2_addr = rs2_q;
    assign vexu2vrf_rd_addr  = rd_q;
    assign vexu2vrf_rd_wdata = res_q;
    assign vexu2vrf_rd_wreq  = (state == ST_WB) ? wen_q : '0;
    assign vexu2dec_done     = (state == ST_WB);
    assign vexu2dec_illegal  = illegal_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_vexu_ctrl.sv
// Self-checking bench for vexu_ctrl: behavioural VRF, scoreboard of expected write-backs.
module tb_vexu_ctrl;

    localparam int LANE    = 8;
    localparam int EW      = 32;
    localparam int MUL_LAT = 3;
    localparam int DW      = LANE * EW;

    logic            clk;
    logic            rst;
    logic            valid;
    logic            ready;
    logic [3:0]      op;
    logic [4:0]      rd, rs1, rs2;
    logic            vm;
    logic [3:0]      vl;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [DW-1:0]   rs1_data, rs2_data, mask_data;
    logic [LANE-1:0] wreq;
    logic [DW-1:0]   wdata;
    logic            done;
    logic            illegal;
    logic [1:0]      dbg_state;

    logic [EW-1:0] vrf [32][LANE];

    typedef struct {
        logic [4:0]      rd;
        logic [LANE-1:0] wreq;
        logic [DW-1:0]   data;
        int              lat;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [LANE-1:0] last_wreq;

    vexu_ctrl #(.LANE(LANE), .EW(EW), .MUL_LAT(MUL_LAT)) dut (
        .clk                (clk),
        .rst                (rst),
        .dec2vexu_valid     (valid),
        .dec2vexu_ready     (ready),
        .dec2vexu_op        (op),
        .dec2vexu_rd        (rd),
        .dec2vexu_rs1       (rs1),
        .dec2vexu_rs2       (rs2),
        .dec2vexu_vm        (vm),
        .dec2vexu_vl        (vl),
        .vexu2vrf_rs1_addr  (rs1_addr),
        .vexu2vrf_rs2_addr  (rs2_addr),
        .vrf2vexu_rs1_data  (rs1_data),
        .vrf2vexu_rs2_data  (rs2_data),
        .vrf2vexu_mask_data (mask_data),
        .vexu2vrf_rd_addr   (rd_addr),
        .vexu2vrf_rd_wreq   (wreq),
        .vexu2vrf_rd_wdata  (wdata),
        .vexu2dec_done      (done),
        .vexu2dec_illegal   (illegal),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < LANE; i++) begin
            rs1_data[i*EW +: EW]  = vrf[rs1_addr][i];
            rs2_data[i*EW +: EW]  = vrf[rs2_addr][i];
            mask_data[i*EW +: EW] = vrf[1][i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] alu_ref(input int o, input logic [EW-1:0] a, input logic [EW-1:0] b);
        logic [2*EW-1:0] p;
        case (o)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << b[4:0];
            6: return a >> b[4:0];
            7: begin p = a * b; return p[EW-1:0]; end
            default: return '0;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   ready, 1);
        check({tag, "_done"},    done, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_wreq"},    wreq, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wdata"},   wdata, 0);
        check({tag, "_rs1"},     rs1_addr, 0);
        check({tag, "_rs2"},     rs2_addr, 0);
        check({tag, "_state"},   dbg_state, 0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int o, input int d, input int s1, input int s2, input bit m, input int l);
        valid = 1'b1;
        op    = 4'(o);
        rd    = 5'(d);
        rs1   = 5'(s1);
        rs2   = 5'(s2);
        vm    = m;
        vl    = 4'(l);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Issue a legal op, push its expectation, then watch the DUT until done pulses.
    task automatic run_op(input string tag, input int o, input int d, input int s1, input int s2,
                          input bit m, input int l);
        exp_t e;
        exp_t g;
        int   vle;
        bit   seen;
        logic [DW-1:0] lane_mask;
        vle    = (l > LANE) ? LANE : l;
        e.rd   = 5'(d);
        e.wreq = '0;
        e.data = '0;
        e.lat  = (o == 7) ? 1 + MUL_LAT : 2;
        for (int i = 0; i < LANE; i++) begin
            if ((i < vle) && (m || vrf[1][i][0])) begin
                e.wreq[i] = 1'b1;
                e.data[i*EW +: EW] = alu_ref(o, vrf[s1][i], vrf[s2][i]);
            end
        end
        exp_q.push_back(e);
        drive(o, d, s1, s2, m, l);
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                g = exp_q.pop_front();
                lane_mask = '0;
                for (int i = 0; i < LANE; i++) if (wreq[i]) lane_mask[i*EW +: EW] = '1;
                check({tag, "_latency"}, k, g.lat);
                check({tag, "_rd_addr"}, rd_addr, g.rd);
                check({tag, "_wreq"}, wreq, g.wreq);
                check({tag, "_wdata"}, wdata & lane_mask, g.data);
                last_wreq = wreq;
                for (int i = 0; i < LANE; i++) if (wreq[i]) vrf[rd_addr][i] = wdata[i*EW +: EW];
            end else begin
                check({tag, "_busy_ready"}, ready, 0);
                check({tag, "_busy_wreq"}, wreq, 0);
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({tag, "_ready_after"}, ready, 1);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit bad;
        logic [EW-1:0] keep [LANE];
        rst = 1'b1;
        valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; vm = 1'b1; vl = '0;
        for (int r = 0; r < 32; r++)
            for (int i = 0; i < LANE; i++) vrf[r][i] = $urandom;
        for (int i = 0; i < LANE; i++) begin
            vrf[4][i] = EW'(i);
            vrf[5][i] = 32'hFFFF_FFFF;
            vrf[1][i] = (i == 0 || i == 2 || i == 5) ? 32'h3 : 32'h2;
            vrf[6][i] = 32'h0001_0000;
            vrf[7][i] = 32'h0001_0001;
            vrf[8][i] = 32'h1;
            vrf[9][i] = 32'h4;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("vadd", 0, 3, 4, 5, 1, 8);
        check("vadd_wreq_ff", last_wreq, 8'hFF);
        check("vadd_lane0", vrf[3][0], 32'hFFFF_FFFF);
        check("vadd_lane7", vrf[3][7], 32'h6);

        for (int i = 0; i < LANE; i++) keep[i] = vrf[3][i];
        run_op("vsub_mask", 1, 3, 4, 5, 0, 8);
        check("vsub_wreq_25", last_wreq, 8'h25);
        check("vsub_lane1_kept", vrf[3][1], keep[1]);
        check("vsub_lane2", vrf[3][2], 32'h3);

        run_op("vmul", 7, 10, 6, 7, 1, 8);
        check("vmul_lane0", vrf[10][0], 32'h0001_0000);

        run_op("vxor_vl3", 4, 11, 12, 13, 1, 3);
        check("vxor_wreq_07", last_wreq, 8'h07);
        run_op("vxor_vl0", 4, 11, 12, 13, 1, 0);
        check("vxor_wreq_00", last_wreq, 8'h00);
        run_op("vand_vl12", 2, 14, 12, 13, 1, 12);
        check("vand_wreq_clamp", last_wreq, 8'hFF);
        run_op("vsrl", 6, 15, 5, 9, 1, 8);
        check("vsrl_logical", vrf[15][0], 32'h0FFF_FFFF);

        // Illegal opcode: single-cycle pulse, no write, controller stays idle.
        drive(9, 3, 4, 5, 1, 8);
        @(negedge clk);
        check("illegal_pulse", illegal, 1);
        check("illegal_ready", ready, 1);
        check("illegal_done", done, 0);
        check("illegal_wreq", wreq, 0);
        @(negedge clk);
        check("illegal_once", illegal, 0);
        run_op("vor_after_illegal", 3, 16, 4, 5, 1, 8);

        // Reset in the middle of a VMUL.
        drive(7, 17, 6, 7, 1, 8);
        @(negedge clk);
        check("abort_in_exec", dbg_state, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wreq != 0 || done) bad = 1;
        end
        check("abort_no_wreq", bad, 0);
        run_op("vsll", 5, 18, 8, 9, 1, 8);
        check("vsll_lane3", vrf[18][3], 32'h10);

        for (int n = 0; n < 25; n++)
            run_op("rand", $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 15));

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
